// File: rtl/classificador_botao.sv
// classificador_botao: turns a debounced, active-high button level into
// registered one-cycle events (press, short click, long press, auto-repeat)
// plus a registered "held" level.
// Optional feature macro: REPETICAO_EN (auto-repeat while held after a long
// press). Without it pulso_repeticao is tied low and no repeat logic is built.
module classificador_botao #(
    parameter int LONGO_CICLOS  = 25_000_000,
    parameter int REPETE_CICLOS = 5_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic botao_in,
    output logic pulso_press,
    output logic pulso_curto,
    output logic pulso_longo,
    output logic pulso_repeticao,
    output logic pressionado
);

    // Counter sized for the larger of the two periods; it is cleared on every
    // threshold hit, so it never needs to hold more than max-1.
    localparam int MAX_CICLOS = (LONGO_CICLOS > REPETE_CICLOS) ? LONGO_CICLOS : REPETE_CICLOS;
    localparam int CNT_W      = $clog2(MAX_CICLOS);

    localparam logic [CNT_W-1:0] LIMITE_LONGO = CNT_W'(LONGO_CICLOS - 1);

    typedef enum logic [1:0] {
        ESPERA_SOLTAR,
        OCIOSO,
        PRESSIONADO,
        LONGO
    } estado_t;

    estado_t          estado,   estado_nxt;
    logic [CNT_W-1:0] contador, contador_nxt;
    logic             press_nxt;
    logic             curto_nxt;
    logic             longo_nxt;
    logic             pressionado_nxt;

`ifdef REPETICAO_EN
    localparam logic [CNT_W-1:0] LIMITE_REPETE = CNT_W'(REPETE_CICLOS - 1);

    logic rep_nxt;
    logic rep_q;
`endif

    // State, counter and every output pulse are registered together.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado      <= ESPERA_SOLTAR;
            contador    <= '0;
            pulso_press <= 1'b0;
            pulso_curto <= 1'b0;
            pulso_longo <= 1'b0;
            pressionado <= 1'b0;
        end else begin
            estado      <= estado_nxt;
            contador    <= contador_nxt;
            pulso_press <= press_nxt;
            pulso_curto <= curto_nxt;
            pulso_longo <= longo_nxt;
            pressionado <= pressionado_nxt;
        end
    end

`ifdef REPETICAO_EN
    // Auto-repeat pulse register, same reset behaviour as the other pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            rep_q <= 1'b0;
        end else begin
            rep_q <= rep_nxt;
        end
    end

    assign pulso_repeticao = rep_q;
`else
    assign pulso_repeticao = 1'b0;
`endif

    // Next-state, counter and pulse decode; release always takes priority
    // over the long-press threshold.
    always_comb begin
        estado_nxt   = estado;
        contador_nxt = '0;
        press_nxt    = 1'b0;
        curto_nxt    = 1'b0;
        longo_nxt    = 1'b0;
`ifdef REPETICAO_EN
        rep_nxt      = 1'b0;
`endif

        case (estado)
            ESPERA_SOLTAR: begin
                // A key held through reset must be released before it counts.
                if (!botao_in) begin
                    estado_nxt = OCIOSO;
                end
            end

            OCIOSO: begin
                if (botao_in) begin
                    estado_nxt = PRESSIONADO;
                    press_nxt  = 1'b1;
                end
            end

            PRESSIONADO: begin
                if (!botao_in) begin
                    estado_nxt = OCIOSO;
                    curto_nxt  = 1'b1;
                end else if (contador == LIMITE_LONGO) begin
                    estado_nxt = LONGO;
                    longo_nxt  = 1'b1;
                end else begin
                    contador_nxt = contador + 1'b1;
                end
            end

            LONGO: begin
                if (!botao_in) begin
                    estado_nxt = OCIOSO;
                end else begin
`ifdef REPETICAO_EN
                    if (contador == LIMITE_REPETE) begin
                        rep_nxt = 1'b1;
                    end else begin
                        contador_nxt = contador + 1'b1;
                    end
`endif
                end
            end

            default: begin
                estado_nxt = ESPERA_SOLTAR;
            end
        endcase

        pressionado_nxt = (estado_nxt == PRESSIONADO) || (estado_nxt == LONGO);
    end

endmodule

// File: tb/tb_classificador_botao.sv
// Self-checking bench for classificador_botao (LONGO_CICLOS=8, REPETE_CICLOS=4).
// The reference model works on run lengths of consecutive pressed samples
// rather than on FSM states.
module tb_classificador_botao;

    localparam int L = 8;
    localparam int R = 4;

    logic clock = 1'b0;
    logic reset;
    logic botao_in;
    logic pulso_press;
    logic pulso_curto;
    logic pulso_longo;
    logic pulso_repeticao;
    logic pressionado;

    classificador_botao #(
        .LONGO_CICLOS (L),
        .REPETE_CICLOS(R)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .botao_in       (botao_in),
        .pulso_press    (pulso_press),
        .pulso_curto    (pulso_curto),
        .pulso_longo    (pulso_longo),
        .pulso_repeticao(pulso_repeticao),
        .pressionado    (pressionado)
    );

    always #5 clock = ~clock;

`ifdef REPETICAO_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: length of the current run of 1-samples, whether
    // a 0-sample has been seen since reset, and whether this run counts.
    int run    = 0;
    bit armed  = 1'b0;
    bit run_ok = 1'b0;

    logic e_press, e_curto, e_longo, e_rep, e_pres;

    // Event counters and timestamps from the DUT, for the directed scenarios.
    int n_press, n_curto, n_longo, n_rep;
    int t_press, t_longo, t_rep_first;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_press = 0; n_curto = 0; n_longo = 0; n_rep = 0;
        t_press = -1; t_longo = -1; t_rep_first = -1;
    endtask

    task automatic model_update(input logic r, input logic b);
        e_press = 1'b0; e_curto = 1'b0; e_longo = 1'b0; e_rep = 1'b0; e_pres = 1'b0;
        if (r) begin
            run = 0; armed = 1'b0; run_ok = 1'b0;
        end else if (!b) begin
            e_curto = run_ok && (run >= 1) && (run <= L);
            run = 0; armed = 1'b1; run_ok = 1'b0;
        end else begin
            if (run == 0) run_ok = armed;
            run++;
            e_press = run_ok && (run == 1);
            e_longo = run_ok && (run == L + 1);
            e_rep   = REP_ON && run_ok && (run > L + 1) && (((run - L - 1) % R) == 0);
            e_pres  = run_ok;
        end
    endtask

    // One clock: drive inputs, let the edge happen, then compare every output.
    task automatic step(input logic r, input logic b);
        int npulse;
        reset = r; botao_in = b;
        @(posedge clock);
        #1;
        cyc++;
        model_update(r, b);
        chk("press", pulso_press, e_press);
        chk("curto", pulso_curto, e_curto);
        chk("longo", pulso_longo, e_longo);
        chk("repeticao", pulso_repeticao, e_rep);
        chk("pressionado", pressionado, e_pres);
        npulse = int'(pulso_press) + int'(pulso_curto) + int'(pulso_longo) + int'(pulso_repeticao);
        checks++;
        if (npulse > 1) begin
            failures++;
            $display("FAIL exclusivity cyc=%0d got=%0d pulses want<=1", cyc, npulse);
        end
        if (pulso_press === 1'b1) begin n_press++; t_press = cyc; end
        if (pulso_curto === 1'b1) n_curto++;
        if (pulso_longo === 1'b1) begin n_longo++; t_longo = cyc; end
        if (pulso_repeticao === 1'b1) begin
            n_rep++;
            if (t_rep_first < 0) t_rep_first = cyc;
        end
    endtask

    initial begin
        reset = 1'b1;
        botao_in = 1'b0;
        clear_counts();

        // 1: reset with key held, held 20 more cycles, then release.
        step(1'b1, 1'b1);
        chk("reset_pressionado", pressionado, 1'b0);
        chk("reset_press", pulso_press, 1'b0);
        repeat (20) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk_int("s1_no_pulses", n_press + n_curto + n_longo + n_rep, 0);
        step(1'b0, 1'b1);
        chk_int("s1_next_press", n_press, 1);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // 2: three-cycle click.
        clear_counts();
        repeat (3) step(1'b0, 1'b1);
        repeat (2) step(1'b0, 1'b0);
        chk_int("s2_press", n_press, 1);
        chk_int("s2_curto", n_curto, 1);
        chk_int("s2_longo", n_longo, 0);

        // 3/4: hold for 30 cycles.
        clear_counts();
        repeat (30) step(1'b0, 1'b1);
        chk_int("s3_longo_count", n_longo, 1);
        chk_int("s3_longo_delay", t_longo - t_press, 8);
        chk_int("s4_rep_count", n_rep, REP_ON ? 5 : 0);
        if (REP_ON) chk_int("s4_rep_first_delay", t_rep_first - t_longo, 4);
        repeat (3) step(1'b0, 1'b0);
        chk_int("s3_no_curto", n_curto, 0);
        chk_int("s4_rep_stops", n_rep, REP_ON ? 5 : 0);

        // 5: release exactly on the threshold sample.
        clear_counts();
        repeat (8) step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        chk_int("s5_curto", n_curto, 1);
        chk_int("s5_no_longo", n_longo, 0);
        step(1'b0, 1'b0);

        // 6: reset pulse while pressed.
        clear_counts();
        repeat (3) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("s6_pressionado", pressionado, 1'b0);
        repeat (12) step(1'b0, 1'b1);
        chk_int("s6_no_pulses", n_press + n_curto + n_longo + n_rep, 1);
        step(1'b0, 1'b0);
        chk_int("s6_no_curto", n_curto, 0);
        step(1'b0, 1'b1);
        chk_int("s6_press_again", n_press, 2);
        step(1'b0, 1'b0);

        // Randomised runs of presses and gaps with occasional resets.
        for (int k = 0; k < 250; k++) begin
            int len;
            int gap;
            case ($urandom_range(0, 3))
                0: len = $urandom_range(1, L - 1);
                1: len = $urandom_range(L - 1, L + 2);
                default: len = $urandom_range(L + 1, L + 6 * R);
            endcase
            gap = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) step(($urandom_range(0, 99) == 0), 1'b1);
            for (int i = 0; i < gap; i++) step(($urandom_range(0, 99) == 0), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
